// File: rtl/fft_in_framer.sv
// rtl/fft_in_framer.sv - Sample FIFO and SOP/EOP framer feeding the streaming FFT sink
// Optional feature macro: FFT_FRAMER_DROP_CNT_EN (adds the saturating drop_cnt output)
module fft_in_framer #(
  parameter int DATA_W  = 32,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              enable,
  input  logic [10:0]       cfg_pts,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [10:0]       out_fftpts,
  output logic              overflow
`ifdef FFT_FRAMER_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;

  typedef enum logic {ST_FIRST, ST_BODY} state_t;

  state_t                state_q, state_d;
  logic [10:0]           cnt_q, cnt_d;
  logic [10:0]           pts_q, pts_d;
  logic                  dv_q, dv_d;
  logic [2*DATA_W-1:0]   data_q, data_d;
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [2*DATA_W-1:0]   fifo_mem_q [DEPTH];

  logic accept, flush, consume, load, pop, bypass, push, drop;
  logic fifo_empty, fifo_full, last_beat;

  // Anything outside the five supported frame sizes falls back to a full 1024-point frame.
  function automatic logic [10:0] legal_pts(input logic [10:0] p);
    case (p)
      11'd64, 11'd128, 11'd256, 11'd512, 11'd1024: legal_pts = p;
      default:                                    legal_pts = 11'd1024;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FIRST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: a started frame always runs to exactly pts_q beats
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FIRST: begin
        if (accept) begin
          state_d = ST_BODY;
          cnt_d   = 11'd1;
        end
      end
      ST_BODY: begin
        if (accept) begin
          if (last_beat) begin
            state_d = ST_FIRST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end
      default: begin
        state_d = ST_FIRST;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: the output register is only exposed when a frame may start or is in progress
  always_comb begin
    last_beat  = (cnt_q == 11'(pts_q - 11'd1));
    flush      = (state_q == ST_FIRST) && !enable;
    out_valid  = dv_q && ((state_q == ST_BODY) || enable);
    out_sop    = out_valid && (state_q == ST_FIRST);
    out_eop    = out_valid && (state_q == ST_BODY) && last_beat;
    accept     = out_valid && out_ready;
    out_real   = data_q[DATA_W-1:0];
    out_imag   = data_q[2*DATA_W-1:DATA_W];
    out_fftpts = pts_q;
    overflow   = overflow_q;
  end

  // Datapath: FIFO bookkeeping, show-ahead refill with empty-FIFO bypass, frame size capture
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(DEPTH));
    // During a flush the held word is thrown away exactly as if it had been accepted.
    consume    = accept || (flush && dv_q);
    load       = !dv_q || consume;
    pop        = load && !fifo_empty;
    bypass     = load && fifo_empty && in_valid;
    push       = in_valid && !bypass && (!fifo_full || pop);
    drop       = in_valid && !bypass && fifo_full && !pop;

    dv_d   = dv_q;
    data_d = data_q;
    if (load) begin
      dv_d = !fifo_empty || in_valid;
      if (!fifo_empty) begin
        data_d = fifo_mem_q[rd_ptr_q];
      end else if (in_valid) begin
        data_d = {in_imag, in_real};
      end
    end

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q || drop;

    // Frame size tracks cfg_pts while nothing is shown in FIRST, and is re-latched on
    // EOP acceptance so a back-to-back SOP already carries the new size.
    pts_d = pts_q;
    if (((state_q == ST_FIRST) && !out_valid) ||
        ((state_q == ST_BODY) && accept && last_beat)) begin
      pts_d = legal_pts(cfg_pts);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dv_q       <= 1'b0;
      data_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      pts_q      <= 11'd1024;
    end else begin
      dv_q       <= dv_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      pts_q      <= pts_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {in_imag, in_real};
    end
  end

`ifdef FFT_FRAMER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped samples
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
    drop_cnt = drop_cnt_q;
  end

  // Drop counter register, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_fft_in_framer.sv
// tb/tb_fft_in_framer.sv - Scoreboard bench for fft_in_framer
module tb_fft_in_framer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_real, in_imag;
  logic        enable;
  logic [10:0] cfg_pts;
  logic        out_valid, out_ready, out_sop, out_eop, overflow;
  logic [31:0] out_real, out_imag;
  logic [10:0] out_fftpts;
`ifdef FFT_FRAMER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  fft_in_framer #(.DATA_W(32), .FIFO_AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_real(in_real),
    .in_imag(in_imag), .enable(enable), .cfg_pts(cfg_pts), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .out_real(out_real),
    .out_imag(out_imag), .out_fftpts(out_fftpts), .overflow(overflow)
`ifdef FFT_FRAMER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sop;
    logic        eop;
    logic [31:0] re;
    logic [31:0] im;
    logic [10:0] pts;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_pos  = 0;
  logic [31:0] seq    = 0;
  bit          rnd_mode  = 1'b0;
  logic        ready_lvl = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one input cycle; keep=1 means the sample must come out, with frame length len.
  task automatic put(input bit v, input bit keep, input int len);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    if (v) begin
      seq++;
      in_real = seq;
      in_imag = ~seq;
      if (keep) begin
        e.sop = (m_pos == 0);
        e.eop = (m_pos == len - 1);
        e.re  = seq;
        e.im  = ~seq;
        e.pts = 11'(len);
        sb_q.push_back(e);
        m_pos = (m_pos + 1) % len;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 1'b0, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    check("drain_left", 128'(sb_q.size()), 128'd0);
  endtask

  // Ready driver: level or random with 75% high
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_lvl;
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and checks stall stability
  initial begin
    exp_t        e;
    logic        stall_prev = 1'b0;
    logic [77:0] snap = '0;
    logic [77:0] cur;
    forever begin
      @(negedge clk);
      cur = {out_valid, out_sop, out_eop, out_real, out_imag, out_fftpts};
      if (reset_n) begin
        if (stall_prev && enable) check("stall_hold", 128'(cur), 128'(snap));
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none at %0t", cur, $time);
          end else begin
            e = sb_q.pop_front();
            check("beat", 128'({out_sop, out_eop, out_real, out_imag, out_fftpts}),
                  128'({e.sop, e.eop, e.re, e.im, e.pts}));
          end
        end
        stall_prev = out_valid && !out_ready;
        snap = cur;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic check_reset_values();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_sop", 128'(out_sop), 128'd0);
    check("rst_out_eop", 128'(out_eop), 128'd0);
    check("rst_out_real", 128'(out_real), 128'd0);
    check("rst_out_imag", 128'(out_imag), 128'd0);
    check("rst_out_fftpts", 128'(out_fftpts), 128'd1024);
    check("rst_overflow", 128'(overflow), 128'd0);
`ifdef FFT_FRAMER_DROP_CNT_EN
    check("rst_drop_cnt", 128'(drop_cnt), 128'd0);
`endif
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
    enable = 1'b1; cfg_pts = 11'd1024;
    repeat (3) @(posedge clk);
    #2;
    check_reset_values();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1024-point frames, continuous input, always ready
    for (int i = 0; i < 2048; i++) put(1'b1, 1'b1, 1024);
    idle(2);
    drain();
    check("no_overflow_1024", 128'(overflow), 128'd0);

    // 64-point frames, half-rate input, random ready
    cfg_pts = 11'd64;
    rnd_mode = 1'b1;
    for (int i = 0; i < 128; i++) begin
      put(1'b1, 1'b1, 64);
      put(1'b0, 1'b0, 64);
    end
    rnd_mode = 1'b0;
    idle(1);
    drain();
    check("no_overflow_64", 128'(overflow), 128'd0);

    // cfg change 256 -> 128 mid-frame only affects the following frame
    cfg_pts = 11'd256;
    for (int i = 0; i < 384; i++) begin
      if (i == 100) cfg_pts = 11'd128;
      put(1'b1, 1'b1, (i < 256) ? 256 : 128);
    end
    idle(2);
    drain();

    // Overflow: 20 samples into a stalled sink, 17 fit
    cfg_pts = 11'd64;
    ready_lvl = 1'b0;
    for (int i = 0; i < 20; i++) put(1'b1, i < 17, 64);
    idle(2);
    check("overflow_set", 128'(overflow), 128'd1);
`ifdef FFT_FRAMER_DROP_CNT_EN
    check("drop_cnt_3", 128'(drop_cnt), 128'd3);
`endif
    ready_lvl = 1'b1;
    for (int i = 0; i < 47; i++) put(1'b1, 1'b1, 64);
    idle(2);
    drain();
    check("overflow_sticky", 128'(overflow), 128'd1);

    // Illegal size 100 falls back to 1024
    cfg_pts = 11'd100;
    idle(2);
    for (int i = 0; i < 1024; i++) put(1'b1, 1'b1, 1024);
    idle(2);
    drain();

    // enable dropped mid-frame: frame completes, later samples are flushed
    cfg_pts = 11'd64;
    idle(2);
    for (int i = 0; i < 64; i++) begin
      if (i == 30) enable = 1'b0;
      put(1'b1, 1'b1, 64);
    end
    for (int i = 0; i < 5; i++) put(1'b1, 1'b0, 64);
    idle(4);
    check("flush_out_valid", 128'(out_valid), 128'd0);
    enable = 1'b1;
    idle(1);
    for (int i = 0; i < 64; i++) put(1'b1, 1'b1, 64);
    idle(2);
    drain();

    // Reset mid-frame clears outputs immediately
    for (int i = 0; i < 20; i++) put(1'b1, 1'b1, 64);
    #2;
    reset_n = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    m_pos = 0;
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 64; i++) put(1'b1, 1'b1, 64);
    idle(2);
    drain();

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_in_framer.md
# fft_in_framer

Input framing stage placed directly upstream of the 1024-point streaming FFT core. It accepts a non-stallable complex sample stream, buffers it in a small FIFO, and emits Avalon-ST frames with SOP/EOP to the FFT sink. Each frame is exactly `fftpts` beats long, and `fftpts_out` is held constant across the frame. Samples that arrive while the FIFO is full are dropped and flagged, so the FFT core never sees a malformed packet.

## Interface
- `DATA_W`, 32: width of the real and imaginary sample words.
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW (16).
- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  sample strobe; no ready, the source cannot stall.
- `in_real`  in  DATA_W  sample, real part.
- `in_imag`  in  DATA_W  sample, imaginary part.
- `enable`  in  1  permits starting new frames.
- `cfg_pts`  in  11  requested frame length; sampled at frame start.
- `out_valid`  out  1  to FFT `sink_valid`.
- `out_ready`  in  1  from FFT `sink_ready`.
- `out_sop`  out  1  to FFT `sink_sop`.
- `out_eop`  out  1  to FFT `sink_eop`.
- `out_real`  out  DATA_W  to FFT `sink_real`.
- `out_imag`  out  DATA_W  to FFT `sink_imag`.
- `out_fftpts`  out  11  to FFT `fftpts_in`.
- `overflow`  out  1  sticky: at least one sample dropped since reset.
- `drop_cnt`  out  16  dropped-sample count; present only with `FFT_FRAMER_DROP_CNT_EN`.

## Operation
- **FIFO write:** on `in_valid` when not full, write {in_imag, in_real}.
  - If full, drop the sample and set `overflow` (sticky until reset).
- **Show-ahead output register:** a beat counts as accepted when `out_valid & out_ready`.
- **FSM state FIRST:**
  - On entry, latch `pts_reg` from `cfg_pts`.
  - Legal `cfg_pts` values are powers of two from 64 to 1024. Any other value latches 1024.
  - With `enable`=1 and data available, present the beat with `out_sop`=1. On acceptance, go to BODY, `cnt`=1.
  - With `enable`=0, pop and discard FIFO words (flush) and keep `out_valid`=0.
- **FSM state BODY:**
  - Present beats with `out_sop`=0. `cnt` increments on each acceptance.
  - `out_eop`=1 when `cnt == pts_reg-1`. On acceptance of EOP, return to FIRST.
- **Frame integrity:**
  - `enable` is only evaluated in FIRST. A frame that has started always completes with exactly `pts_reg` beats.
  - `out_fftpts` = `pts_reg`, constant from SOP through EOP.
- **Counter width:** `cnt` is 11 bits. It never reaches `pts_reg`, so there is no wrap inside a frame.

## Timing
- **Reset values:** `out_valid`, `out_sop`, `out_eop`, `overflow`, `drop_cnt` = 0; `out_real`, `out_imag` = 0; `out_fftpts` = 1024. FSM state = FIRST, FIFO empty.
- **Latency:** a write in cycle t into an empty FIFO gives `out_valid`=1 in cycle t+1.
- **Stall rule:** while `out_valid & !out_ready`, all `out_*` signals hold stable.
  - `out_valid` never deasserts without acceptance, except during a flush when `enable`=0.
- **Back-to-back frames:** the next SOP may be presented in the cycle after EOP acceptance, provided data is available. There is no mandatory bubble.
- **Simultaneous read and write when full:** the read frees a slot and the write is accepted, with no drop.
- **Simultaneous read and write when empty:** the write goes to the output register on the following cycle.
- **Throughput:** 1 beat/cycle when `out_ready` is held at 1.
- **`cfg_pts` timing:** changes during BODY have no effect until the next FIRST.
- **Reset mid-frame:** asynchronous clear takes effect immediately. The partial frame is abandoned; the FFT core is reset by the same `reset_n`.

## Configuration
- **`FFT_FRAMER_DROP_CNT_EN` defined:** adds the 16-bit `drop_cnt` output.
  - Increments once per dropped sample and saturates at 0xFFFF.
  - Cleared only by reset.
- **Not defined:** `drop_cnt` port and its logic are absent. Only the sticky `overflow` remains.

## Test plan
- `cfg_pts`=1024, continuous `in_valid`, `out_ready`=1 → SOP on beat 1, EOP on beat 1024, next SOP on beat 1025. Data equals the input sequence; `overflow`=0.
- `cfg_pts`=64, `in_valid` at 50% duty, random `out_ready` → every frame has 64 beats, data stable during stalls, no loss.
- `cfg_pts` changed from 256 to 128 at beat 100 of a frame → current frame ends at beat 256, next frame is 128 beats, `out_fftpts`=128 from that SOP.
- `out_ready`=0, 20 samples written (depth 16 + output register) → 3 dropped, `overflow`=1, `drop_cnt`=3 (macro on). Data delivered afterwards is the first 17 samples in order.
- `cfg_pts`=100 → frame length 1024, `out_fftpts`=1024.
- `enable` dropped mid-frame, and `reset_n` asserted mid-frame:
  - `enable` low: the frame completes, then the FIFO flushes and `out_valid`=0.
  - `reset_n` low: all outputs take their reset values within the same cycle.
